osnt_pkt_drop_fifo: RTL and testbench

//  Store-and-forward packet buffer directly downstream of the packet cutter, ahead of the DMA/host path.

---
 rtl/osnt_pkt_drop_fifo_if.sv | 15 +
 rtl/osnt_pkt_drop_fifo.sv | 142 ++++++++++++++
 tb/tb_osnt_pkt_drop_fifo.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/osnt_pkt_drop_fifo_if.sv
// AXI4-Stream bundle used on both sides of the packet drop FIFO.
interface osnt_pkt_drop_fifo_if #(
  parameter int DW = 1024,
  parameter int UW = 128
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/osnt_pkt_drop_fifo.sv
// Store-and-forward packet FIFO that drops whole packets instead of backpressuring.
// Optional peak-occupancy tracking is built when OSNT_DROP_FIFO_HWM_EN is defined.
module osnt_pkt_drop_fifo #(
  parameter int C_AXIS_DATA_WIDTH  = 1024,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int DEPTH_LOG2         = 6
) (
  input  logic                 axi_aclk,
  input  logic                 axi_resetn,
  osnt_pkt_drop_fifo_if.slave  s_axis,
  osnt_pkt_drop_fifo_if.master m_axis,
  input  logic                 cnt_clear,
  output logic [31:0]          pkt_in_cnt,
  output logic [31:0]          pkt_drop_cnt,
  output logic [31:0]          pkt_out_cnt,
  output logic [DEPTH_LOG2:0]  occ_hwm
);
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int KW = DW / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int EW = DW + KW + UW + 1;
  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PW-1:0] ONE   = PW'(1);

  typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_e;

  wr_state_e     st, st_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt, wr_commit, wr_commit_nxt, rd_ptr, occ;
  logic [EW-1:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic          s_beat, s_last, full, wr_en, drop_done, rd_avail, m_last_hs;

  assign s_axis.tready = axi_resetn;
  assign s_beat        = s_axis.tvalid & axi_resetn;
  assign s_last        = s_beat & s_axis.tlast;
  assign occ           = wr_ptr - rd_ptr;
  assign full          = (occ == DEPTH);
  assign rd_avail      = (rd_ptr != wr_commit);
  assign m_last_hs     = m_axis.tvalid & m_axis.tready & m_axis.tlast;

  // A full buffer on any beat condemns the whole packet; wr_ptr rewinds on its tlast.
  always_comb begin
    st_nxt        = st;
    wr_ptr_nxt    = wr_ptr;
    wr_commit_nxt = wr_commit;
    wr_en         = 1'b0;
    drop_done     = 1'b0;
    case (st)
      WR_IDLE, WR_PKT: begin
        if (s_beat) begin
          if (full) begin
            if (s_axis.tlast) begin
              wr_ptr_nxt = wr_commit;
              drop_done  = 1'b1;
              st_nxt     = WR_IDLE;
            end else begin
              st_nxt = WR_DROP;
            end
          end else begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + ONE;
            if (s_axis.tlast) begin
              wr_commit_nxt = wr_ptr + ONE;
              st_nxt        = WR_IDLE;
            end else begin
              st_nxt = WR_PKT;
            end
          end
        end
      end
      WR_DROP: begin
        if (s_last) begin
          wr_ptr_nxt = wr_commit;
          drop_done  = 1'b1;
          st_nxt     = WR_IDLE;
        end
      end
      default: st_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      st        <= WR_IDLE;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      st        <= st_nxt;
      wr_ptr    <= wr_ptr_nxt;
      wr_commit <= wr_commit_nxt;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (wr_en)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis.tdata, s_axis.tkeep, s_axis.tuser, s_axis.tlast};
  end

  // The output register is the memory read stage; it refills whenever it empties or drains.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      rd_ptr        <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tkeep  <= '0;
      m_axis.tuser  <= '0;
      m_axis.tlast  <= 1'b0;
    end else if (!m_axis.tvalid || m_axis.tready) begin
      m_axis.tvalid <= rd_avail;
      if (rd_avail) begin
        {m_axis.tdata, m_axis.tkeep, m_axis.tuser, m_axis.tlast} <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        rd_ptr <= rd_ptr + ONE;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pkt_in_cnt   <= '0;
      pkt_drop_cnt <= '0;
      pkt_out_cnt  <= '0;
    end else if (cnt_clear) begin
      pkt_in_cnt   <= '0;
      pkt_drop_cnt <= '0;
      pkt_out_cnt  <= '0;
    end else begin
      if (s_last)    pkt_in_cnt   <= pkt_in_cnt + 32'd1;
      if (drop_done) pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
      if (m_last_hs) pkt_out_cnt  <= pkt_out_cnt + 32'd1;
    end
  end

`ifdef OSNT_DROP_FIFO_HWM_EN
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn)       occ_hwm <= '0;
    else if (cnt_clear)    occ_hwm <= '0;
    else if (occ > occ_hwm) occ_hwm <= occ;
  end
`else
  assign occ_hwm = '0;
`endif
endmodule

// File: tb/tb_osnt_pkt_drop_fifo.sv
// Bench for osnt_pkt_drop_fifo: queue-based packet model checked every cycle plus literal checkpoints.
module tb_osnt_pkt_drop_fifo;
  localparam int DW = 32, UW = 8, KW = DW/8, DL = 6, DEPTH = 64;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic clk = 1'b0, rst_n = 1'b0, cnt_clear = 1'b0, rand_rdy = 1'b0;
  logic [31:0] pkt_in_cnt, pkt_drop_cnt, pkt_out_cnt;
  logic [DL:0] occ_hwm;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  osnt_pkt_drop_fifo_if #(.DW(DW), .UW(UW)) s_if ();
  osnt_pkt_drop_fifo_if #(.DW(DW), .UW(UW)) m_if ();

  osnt_pkt_drop_fifo #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .DEPTH_LOG2(DL)) dut (
    .axi_aclk(clk), .axi_resetn(rst_n), .s_axis(s_if), .m_axis(m_if), .cnt_clear(cnt_clear),
    .pkt_in_cnt(pkt_in_cnt), .pkt_drop_cnt(pkt_drop_cnt), .pkt_out_cnt(pkt_out_cnt), .occ_hwm(occ_hwm)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: buffer content = beats written minus beats taken into the output register.
  beat_t expq[$], cur[$], held;
  int written = 0, committed = 0, out_beats = 0;
  int e_in = 0, e_drop = 0, e_out = 0, e_hwm = 0;
  bit dropping = 0, stall = 0;

  always @(negedge clk) begin
    int occ;
    beat_t b, got, e;
    got = {m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast};
    if (!rst_n) begin
      chk("rst_m_tvalid", 64'(m_if.tvalid), 0);
      chk("rst_m_beat", 64'(got), 0);
      chk("rst_s_tready", 64'(s_if.tready), 0);
      chk("rst_in_cnt", 64'(pkt_in_cnt), 0);
      chk("rst_out_cnt", 64'(pkt_out_cnt), 0);
      chk("rst_drop_cnt", 64'(pkt_drop_cnt), 0);
      chk("rst_occ_hwm", 64'(occ_hwm), 0);
      expq.delete(); cur.delete();
      written = 0; committed = 0; out_beats = 0; dropping = 0; stall = 0;
      e_in = 0; e_drop = 0; e_out = 0; e_hwm = 0;
    end else begin
      chk("s_tready", 64'(s_if.tready), 1);
      chk("pkt_in_cnt", 64'(pkt_in_cnt), 64'(e_in));
      chk("pkt_drop_cnt", 64'(pkt_drop_cnt), 64'(e_drop));
      chk("pkt_out_cnt", 64'(pkt_out_cnt), 64'(e_out));
      chk("occ_hwm", 64'(occ_hwm), 64'(e_hwm));
      if (stall) begin
        chk("stall_tvalid", 64'(m_if.tvalid), 1);
        chk("stall_beat", 64'(got), 64'(held));
      end
      occ = written - out_beats - (m_if.tvalid ? 1 : 0);
      if (m_if.tvalid && m_if.tready) begin
        chk("out_beat_expected", 64'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("out_beat", 64'(got), 64'(e));
        end
        out_beats++;
        if (m_if.tlast) e_out++;
      end
      stall = m_if.tvalid && !m_if.tready;
      held  = got;
      if (s_if.tvalid) begin
        b = {s_if.tdata, s_if.tkeep, s_if.tuser, s_if.tlast};
        if (b.l) e_in++;
        if (!dropping && occ == DEPTH) dropping = 1;
        if (dropping) begin
          if (b.l) begin
            dropping = 0; written = committed; cur.delete(); e_drop++;
          end
        end else begin
          cur.push_back(b);
          written++;
          if (b.l) begin
            foreach (cur[i]) expq.push_back(cur[i]);
            cur.delete();
            committed = written;
          end
        end
      end
`ifdef OSNT_DROP_FIFO_HWM_EN
      if (occ > e_hwm) e_hwm = occ;
`endif
      if (cnt_clear) begin
        e_in = 0; e_drop = 0; e_out = 0; e_hwm = 0;
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
    if (rand_rdy) m_if.tready = ($urandom_range(0, 99) < 60);
  endtask

  task automatic send_pkt(input int len, input int gap, input bit clr_last = 0);
    for (int b = 0; b < len; b++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = DW'($urandom);
      s_if.tkeep  = KW'($urandom);
      s_if.tuser  = UW'($urandom);
      s_if.tlast  = (b == len - 1);
      cnt_clear   = clr_last && (b == len - 1);
      sync();
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; cnt_clear = 1'b0;
    for (int g = 0; g < gap; g++) sync();
  endtask

  task automatic pulse_clear();
    cnt_clear = 1'b1; sync(); cnt_clear = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    rand_rdy = 1'b0; m_if.tready = 1'b1;
    while ((expq.size() != 0 || m_if.tvalid) && n < 1000) begin sync(); n++; end
    chk({nm, "_drain_in_time"}, 64'(n < 1000), 1);
  endtask

  task automatic lit3(input string nm, input int in_e, input int out_e, input int drop_e);
    @(negedge clk);
    chk({nm, "_in"}, 64'(pkt_in_cnt), 64'(in_e));
    chk({nm, "_out"}, 64'(pkt_out_cnt), 64'(out_e));
    chk({nm, "_drop"}, 64'(pkt_drop_cnt), 64'(drop_e));
    sync();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    s_if.tvalid = 0; s_if.tlast = 0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sync();

    // 1: three 4-beat packets straight through
    for (int p = 0; p < 3; p++) send_pkt(4, 0);
    drain("t1");
    lit3("t1", 3, 3, 0);

    // 2: stalled output, 20 packets of 4 beats; only 16 fit
    pulse_clear();
    m_if.tready = 1'b0;
    for (int p = 0; p < 20; p++) send_pkt(4, 0);
    @(negedge clk);
`ifdef OSNT_DROP_FIFO_HWM_EN
    chk("t2_hwm", 64'(occ_hwm), 64);
`else
    chk("t2_hwm", 64'(occ_hwm), 0);
`endif
    sync();
    lit3("t2_full", 20, 0, 4);
    drain("t2");
    lit3("t2_drained", 20, 16, 4);

    // 3: 65-beat packet never fits, buffer remains usable afterwards
    pulse_clear();
    send_pkt(65, 2);
    @(negedge clk);
    chk("t3_tvalid_low", 64'(m_if.tvalid), 0);
    sync();
    lit3("t3_drop", 1, 0, 1);
    send_pkt(2, 0);
    drain("t3");
    lit3("t3_after", 2, 1, 1);

    // 4: random backpressure, mixed packet lengths
    pulse_clear();
    rand_rdy = 1'b1;
    for (int p = 0; p < 14; p++) send_pkt($urandom_range(1, 10), $urandom_range(0, 6));
    drain("t4");
    lit3("t4", 14, 14 - e_drop, e_drop);

    // 5: reset in the middle of a packet while a committed packet waits on output
    m_if.tready = 1'b0;
    send_pkt(2, 3);
    @(negedge clk);
    chk("t5_pre_tvalid", 64'(m_if.tvalid), 1);
    sync();
    for (int b = 0; b < 2; b++) begin
      s_if.tvalid = 1'b1; s_if.tdata = DW'($urandom); s_if.tkeep = '1; s_if.tuser = UW'(b); s_if.tlast = 1'b0;
      sync();
    end
    s_if.tvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_tvalid", 64'(m_if.tvalid), 0);
    chk("t5_rst_tdata", 64'(m_if.tdata), 0);
    sync();
    rst_n = 1'b1;
    m_if.tready = 1'b1;
    sync();
    send_pkt(3, 0);
    drain("t5");
    lit3("t5", 1, 1, 0);

    // 6: clear coincident with an input tlast
    m_if.tready = 1'b0;
    send_pkt(3, 0, 1'b1);
    @(negedge clk);
    chk("t6_in", 64'(pkt_in_cnt), 0);
    chk("t6_out", 64'(pkt_out_cnt), 0);
    chk("t6_drop", 64'(pkt_drop_cnt), 0);
    chk("t6_hwm", 64'(occ_hwm), 0);
    sync();
    drain("t6");
    lit3("t6_after", 0, 1, 0);

    chk("end_expq_empty", 64'(expq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
